// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, fixed constants
// and the PC increment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc4} holding register that catches a word returned while decode
// is stalled.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_clr,
    input  logic        i_ld,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_full
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_full;

    // Clear wins over load so a flush that coincides with a capture leaves the entry empty.
    always_ff @(posedge CLK) begin
        if (RST || i_clr) begin
            r_instr <= NOP;
            r_pc4   <= 32'h0;
            r_full  <= 1'b0;
        end else if (i_ld) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_full  <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_full  = r_full;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, the IF/ID pipeline register and a one-entry
// skid buffer so a word returned during a decode stall is not lost.
module fetch_stage
    import fetch_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] pc_plus4,
    output logic        pc_ld
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc4;
    logic        r_if_valid;

    logic [31:0] w_pc4;
    logic [31:0] w_br_pc;
    logic        w_fetch;
    logic        w_skid_ld;
    logic        w_skid_clr;
    logic [31:0] w_skid_instr;
    logic [31:0] w_skid_pc4;
    logic        w_skid_full;

    assign w_pc4      = pc_inc(r_pc);
    assign w_br_pc    = br_target & 32'hFFFF_FFFC;
    assign w_fetch    = (r_state == FETCH);
    assign w_skid_ld  = w_fetch && imem_ack && stall && !br_taken;
    // The entry is consumed when a held word moves into IF/ID, and dropped on a flush.
    assign w_skid_clr = br_taken || ((r_state == HELD) && !stall);

    fetch_skid_buffer u_skid (
        .CLK     (CLK),
        .RST     (RST),
        .i_clr   (w_skid_clr),
        .i_ld    (w_skid_ld),
        .i_instr (imem_rdata),
        .i_pc4   (w_pc4),
        .o_instr (w_skid_instr),
        .o_pc4   (w_skid_pc4),
        .o_full  (w_skid_full)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_if_instr <= NOP;
            r_if_pc4   <= 32'h0;
            r_if_valid <= 1'b0;
        end else if (br_taken) begin
            r_state    <= FETCH;
            r_pc       <= w_br_pc;
            r_if_instr <= NOP;
            r_if_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: r_state <= FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        r_pc <= w_pc4;
                        if (stall) begin
                            r_state <= HELD;
                        end else begin
                            r_if_instr <= imem_rdata;
                            r_if_pc4   <= w_pc4;
                            r_if_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        r_if_valid <= 1'b0;
                    end
                end
                HELD: begin
                    if (!stall) begin
                        r_if_instr <= w_skid_instr;
                        r_if_pc4   <= w_skid_pc4;
                        r_if_valid <= w_skid_full;
                        r_state    <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem_req    = w_fetch;
    assign imem_addr   = r_pc;
    assign pc_plus4    = w_pc4;
    assign pc_ld       = w_fetch && imem_ack && !br_taken;
    assign if_id_instr = r_if_instr;
    assign if_id_pc4   = r_if_pc4;
    assign if_id_valid = r_if_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural PC/state model plus a queue of words
// expected to reach IF/ID, compared with immediate assertions.
module tb_fetch_stage;

    localparam int S_IDLE  = 0;
    localparam int S_FETCH = 1;
    localparam int S_HELD  = 2;

    logic        CLK;
    logic        RST;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] pc_plus4;
    logic        pc_ld;

    int checks = 0;
    int errors = 0;

    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_if_instr;
    logic [31:0] m_if_pc4;
    logic        m_if_valid;
    logic [63:0] sb_q[$];

    fetch_stage dut (
        .CLK         (CLK),
        .RST         (RST),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .pc_plus4    (pc_plus4),
        .pc_ld       (pc_ld)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".if_id_valid"}, {31'b0, if_id_valid}, {31'b0, m_if_valid});
        chk({tag, ".if_id_instr"}, if_id_instr, m_if_instr);
        chk({tag, ".if_id_pc4"},   if_id_pc4,   m_if_pc4);
    endtask

    task automatic do_reset(input logic st, input logic ak, input logic br);
        RST = 1'b1; stall = st; imem_ack = ak; br_taken = br; br_target = 32'h0000_0040;
        @(posedge CLK); #1;
        m_state = S_IDLE; m_pc = 32'h0;
        m_if_instr = 32'h0; m_if_pc4 = 32'h0; m_if_valid = 1'b0;
        sb_q.delete();
        chk_regs("reset");
        chk("reset.imem_req",  {31'b0, imem_req}, 32'h0);
        chk("reset.pc_ld",     {31'b0, pc_ld},    32'h0);
        chk("reset.imem_addr", imem_addr,         32'h0);
        RST = 1'b0;
    endtask

    task automatic step(input logic st, input logic ak, input logic br, input logic [31:0] tgt);
        logic        load;
        logic [63:0] ent;
        stall = st; imem_ack = ak; br_taken = br; br_target = tgt;
        #1;
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_state == S_FETCH});
        if (m_state == S_FETCH) chk("imem_addr", imem_addr, m_pc);
        chk("pc_ld", {31'b0, pc_ld}, {31'b0, (m_state == S_FETCH) && ak && !br});
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        load = 1'b0;
        if (br) begin
            if (m_state == S_HELD) void'(sb_q.pop_back());
            m_pc = tgt & 32'hFFFF_FFFC;
            m_state = S_FETCH;
            m_if_valid = 1'b0;
            m_if_instr = 32'h0;
        end else begin
            case (m_state)
                S_IDLE: m_state = S_FETCH;
                S_FETCH: begin
                    if (ak) begin
                        sb_q.push_back({mem_word(m_pc), m_pc + 32'd4});
                        m_pc = m_pc + 32'd4;
                        if (st) m_state = S_HELD;
                        else    load = 1'b1;
                    end else if (!st) begin
                        m_if_valid = 1'b0;
                    end
                end
                default: begin
                    if (!st) begin
                        load = 1'b1;
                        m_state = S_FETCH;
                    end
                end
            endcase
        end
        if (load) begin
            ent = sb_q.pop_front();
            m_if_instr = ent[63:32];
            m_if_pc4   = ent[31:0];
            m_if_valid = 1'b1;
        end
        @(posedge CLK); #1;
        chk_regs("edge");
    endtask

    initial begin
        RST = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; imem_ack = 1'b0;
        do_reset(1'b0, 1'b0, 1'b0);
        step(0, 1, 0, 32'h0);             // IDLE cycle after reset
        step(0, 1, 0, 32'h0);             // fetch 0
        step(0, 1, 0, 32'h0);             // fetch 4
        step(1, 1, 0, 32'h0);             // fetch 8 under stall -> HELD
        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);             // release: word@8
        step(0, 1, 0, 32'h0);             // fetch 12
        step(0, 0, 0, 32'h0);             // bubbles at 16
        step(0, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);             // no ack, stalled: hold
        step(0, 1, 0, 32'h0);             // fetch 16
        step(1, 1, 0, 32'h0);             // fetch 20 -> HELD
        step(1, 1, 1, 32'h0000_0103);     // flush while HELD
        step(0, 1, 0, 32'h0);             // fetch 0x100
        step(0, 1, 1, 32'h0000_0202);     // ack dropped by branch
        step(0, 1, 1, 32'hFFFF_FFFE);     // redirect to top of address space
        step(0, 1, 0, 32'h0);             // fetch FFFFFFFC, pc4 wraps to 0
        step(0, 1, 0, 32'h0);             // fetch 0
        do_reset(1'b0, 1'b1, 1'b1);
        step(0, 0, 1, 32'h0000_0050);     // branch in IDLE
        step(0, 1, 0, 32'h0);             // fetch 0x50
        step(1, 1, 0, 32'h0);             // fetch 0x54 -> HELD
        do_reset(1'b1, 1'b1, 1'b0);       // reset mid-HELD drops buffered word
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
